// File: rtl/conv_engine_pkg.sv
// Shared constants and helpers for the convolution engine: width arithmetic
// and window element indexing.
package conv_engine_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Element n of the flattened window, n = row*K+col, row 0 oldest.
    function automatic int win_idx(input int row, input int col, input int k);
        return row * k + col;
    endfunction

    // {1'b0,pixel} (BITS+1 signed) times a BITS-wide signed weight.
    function automatic int prod_w(input int bits);
        return 2 * bits + 1;
    endfunction

    function automatic int acc_w(input int bits, input int count);
        return 2 * bits + 1 + clog2(count);
    endfunction

endpackage

// File: rtl/conv_engine_mac_adder_tree.sv
// Registered signed sum of COUNT products; forms the second pipeline stage.
module mac_adder_tree
    import conv_engine_pkg::*;
#(
    parameter int COUNT = 9,
    parameter int IN_W  = 19,
    parameter int OUT_W = 23
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  terms [COUNT],
    output logic signed [OUT_W-1:0] sum,
    output logic                    out_valid
);

    logic signed [OUT_W-1:0] total;

    always_comb begin
        total = '0;
        for (int n = 0; n < COUNT; n++) begin
            total = total + OUT_W'(terms[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) sum <= total;
        end
    end

endmodule

// File: rtl/conv_engine.sv
// K*K convolution engine: serial weight load, product stage, adder tree,
// shift and saturate; windows straddling a row edge are suppressed.
module conv_engine
    import conv_engine_pkg::*;
#(
    parameter int BITS        = 9,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_LENGTH  = 16,
    parameter int SHIFT       = 0
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    weight_load,
    input  logic [BITS-1:0]                         weight_in,
    input  logic                                    window_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] window,
    output logic                                    weights_ready,
    output logic                                    pix_valid,
    output logic [BITS-1:0]                         pix_out
);

    localparam int N      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PROD_W = prod_w(BITS);
    localparam int ACC_W  = acc_w(BITS, N);
    localparam int IDX_W  = clog2(N);
    localparam int COL_W  = clog2(IMG_LENGTH);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << BITS) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = '0;

    logic signed [BITS-1:0]   weights [N];
    logic [IDX_W-1:0]         idx;
    logic [COL_W-1:0]         col;
    logic                     accept;
    logic signed [PROD_W-1:0] prods [N];
    logic                     s1_valid;
    logic signed [ACC_W-1:0]  sum;
    logic                     s2_valid;
    logic signed [ACC_W-1:0]  shifted;

    // A load while ready restarts the sequence at w[0]; other slots keep old values.
    always_ff @(posedge clk) begin
        if (reset) begin
            weights_ready <= 1'b0;
            idx           <= '0;
            for (int n = 0; n < N; n++) weights[n] <= '0;
        end else if (weight_load) begin
            if (weights_ready) begin
                weights[0]    <= weight_in;
                idx           <= IDX_W'(1);
                weights_ready <= 1'b0;
            end else begin
                weights[idx] <= weight_in;
                if (idx == IDX_W'(N - 1)) begin
                    idx           <= '0;
                    weights_ready <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
        end else if (window_valid) begin
            col <= (col == COL_W'(IMG_LENGTH - 1)) ? '0 : col + 1'b1;
        end
    end

    // window_valid is a one-cycle strobe with no ready: a window not accepted
    // in its own cycle is dropped, and accepted windows are never stalled.
    assign accept = window_valid && weights_ready && !weight_load
                    && (int'(col) <= IMG_LENGTH - KERNEL_SIZE);

    always_ff @(posedge clk) begin
        if (reset) s1_valid <= 1'b0;
        else       s1_valid <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    prods[win_idx(r, c, KERNEL_SIZE)] <=
                        PROD_W'($signed({1'b0, window[BITS*win_idx(r, c, KERNEL_SIZE) +: BITS]}))
                        * PROD_W'(weights[win_idx(r, c, KERNEL_SIZE)]);
                end
            end
        end
    end

    mac_adder_tree #(
        .COUNT (N),
        .IN_W  (PROD_W),
        .OUT_W (ACC_W)
    ) u_tree (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .terms     (prods),
        .sum       (sum),
        .out_valid (s2_valid)
    );

    assign shifted = sum >>> SHIFT;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_out   <= '0;
        end else begin
            pix_valid <= s2_valid;
            if (s2_valid) begin
                if (shifted < SAT_MIN)      pix_out <= '0;
                else if (shifted > SAT_MAX) pix_out <= BITS'(SAT_MAX);
                else                        pix_out <= BITS'(shifted);
            end
        end
    end

endmodule

// File: tb/tb_conv_engine.sv
// Randomised and directed checks of conv_engine (SHIFT=0 and SHIFT=4 instances)
// against a cycle-indexed behavioural model.
module tb_conv_engine;

    localparam int B  = 9;
    localparam int K  = 3;
    localparam int N  = 9;
    localparam int L  = 16;
    localparam int WW = N * B;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          weight_load = 1'b0;
    logic [B-1:0]  weight_in = '0;
    logic          window_valid = 1'b0;
    logic [WW-1:0] window = '0;
    logic          weights_ready0, weights_ready4;
    logic          pix_valid0, pix_valid4;
    logic [B-1:0]  pix_out0, pix_out4;

    always #5 clk = ~clk;

    conv_engine #(.BITS(B), .KERNEL_SIZE(K), .IMG_LENGTH(L), .SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .weight_load(weight_load), .weight_in(weight_in),
        .window_valid(window_valid), .window(window), .weights_ready(weights_ready0),
        .pix_valid(pix_valid0), .pix_out(pix_out0)
    );

    conv_engine #(.BITS(B), .KERNEL_SIZE(K), .IMG_LENGTH(L), .SHIFT(4)) dut4 (
        .clk(clk), .reset(reset), .weight_load(weight_load), .weight_in(weight_in),
        .window_valid(window_valid), .window(window), .weights_ready(weights_ready4),
        .pix_valid(pix_valid4), .pix_out(pix_out4)
    );

    // Model state: meaning "as seen after the next rising edge".
    int            w_m [N];
    int            idx_m = 0;
    bit            ready_m = 1'b0;
    int            col_m = 0;
    int            cyc = 0;
    int            due_q [$];
    logic [B-1:0]  exp_q0 [$];
    logic [B-1:0]  exp_q4 [$];
    logic [B-1:0]  last0 = '0, last4 = '0;
    int            total = 0, bad = 0, printed = 0;
    int            pulses = 0;
    int            z [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            if (printed < 40) begin
                printed++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
            end
        end
    endtask

    function automatic logic [WW-1:0] pack(input int p [N]);
        logic [WW-1:0] v;
        v = '0;
        for (int n = 0; n < N; n++) v[B*n +: B] = B'(p[n]);
        return v;
    endfunction

    // Plain dot product, arithmetic shift, clamp to the unsigned pixel range.
    function automatic logic [B-1:0] model_px(input int p [N], input int w [N], input int sh);
        int s;
        s = 0;
        for (int n = 0; n < N; n++) s += p[n] * w[n];
        s = s >>> sh;
        if (s < 0) s = 0;
        if (s > 511) s = 511;
        return B'(s);
    endfunction

    task automatic cycle(input bit rst, input bit wl, input int wval, input bit wv, input int px [N]);
        @(negedge clk);
        reset        = rst;
        weight_load  = wl;
        weight_in    = B'(wval);
        window_valid = wv;
        window       = pack(px);
        if (rst) begin
            foreach (w_m[i]) w_m[i] = 0;
            idx_m = 0; ready_m = 1'b0; col_m = 0;
            due_q.delete(); exp_q0.delete(); exp_q4.delete();
        end else begin
            if (wv && ready_m && !wl && col_m <= L - K) begin
                due_q.push_back(cyc + 3);
                exp_q0.push_back(model_px(px, w_m, 0));
                exp_q4.push_back(model_px(px, w_m, 4));
            end
            if (wl) begin
                if (ready_m) begin
                    w_m[0] = wval; idx_m = 1; ready_m = 1'b0;
                end else begin
                    w_m[idx_m] = wval;
                    if (idx_m == N - 1) begin idx_m = 0; ready_m = 1'b1; end
                    else idx_m++;
                end
            end
            if (wv) col_m = (col_m + 1) % L;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 1'b0, z);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0, 1'b0, z);
        cycle(1'b1, 1'b0, 0, 1'b0, z);
    endtask

    task automatic load_w(input int ws [N]);
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, ws[i], 1'b0, z);
    endtask

    task automatic send(input int px [N]);
        cycle(1'b0, 1'b0, 0, 1'b1, px);
    endtask

    // Probe the output of a window sent just now, three clocks after it was presented.
    task automatic probe_after_send(output logic v0, output logic [B-1:0] o0, output logic [B-1:0] o4);
        idle();
        idle();
        @(posedge clk);
        #2;
        v0 = pix_valid0; o0 = pix_out0; o4 = pix_out4;
    endtask

    // Compare process: every cycle, both instances against the model.
    initial begin
        logic rst_s;
        forever begin
            @(posedge clk);
            rst_s = reset;
            #1;
            if (rst_s) begin
                last0 = '0; last4 = '0;
                check("rst_valid0", pix_valid0, 0);
                check("rst_out0", pix_out0, 0);
                check("rst_valid4", pix_valid4, 0);
                check("rst_out4", pix_out4, 0);
            end else if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                last0 = exp_q0.pop_front();
                last4 = exp_q4.pop_front();
                check("valid0", pix_valid0, 1);
                check("out0", pix_out0, last0);
                check("valid4", pix_valid4, 1);
                check("out4", pix_out4, last4);
            end else begin
                check("idle_valid0", pix_valid0, 0);
                check("hold_out0", pix_out0, last0);
                check("idle_valid4", pix_valid4, 0);
                check("hold_out4", pix_out4, last4);
            end
            check("ready0", weights_ready0, ready_m);
            check("ready4", weights_ready4, ready_m);
            if (!rst_s && pix_valid0) pulses++;
        end
    end

    initial begin
        int ones [N], ident [N], neg [N], wr [N], px [N], p511 [N], p100 [N];
        logic v0;
        logic [B-1:0] o0, o4;
        foreach (z[i]) z[i] = 0;
        foreach (w_m[i]) w_m[i] = 0;
        foreach (ones[i]) begin
            ones[i] = 1; ident[i] = 0; neg[i] = 0; p511[i] = 511; p100[i] = 100;
        end
        ident[4] = 1;
        neg[4] = -1;

        // Reset, then windows with no weights loaded must never produce output.
        do_reset();
        check("reset_ready", weights_ready0, 0);
        for (int i = 0; i < 5; i++) begin
            foreach (px[j]) px[j] = $urandom_range(0, 511);
            send(px);
        end
        idle(); idle(); idle();

        // All-ones kernel on a ramp window.
        do_reset();
        load_w(ones);
        px = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
        send(px);
        probe_after_send(v0, o0, o4);
        check("ramp_valid", v0, 1);
        check("ramp_sum", o0, 153);
        check("ramp_shift4", o4, 9);

        // Identity kernel, then negated centre clamps low.
        load_w(ident);
        px = '{5, 6, 7, 8, 17, 9, 10, 11, 12};
        send(px);
        probe_after_send(v0, o0, o4);
        check("ident_out", o0, 17);
        load_w(neg);
        send(px);
        probe_after_send(v0, o0, o4);
        check("clamp_low_valid", v0, 1);
        check("clamp_low_out", o0, 0);

        // Saturation high and shifted result.
        load_w(ones);
        send(p511);
        probe_after_send(v0, o0, o4);
        check("sat_high", o0, 511);
        check("sat_shift4", o4, 287);
        send(p100);
        probe_after_send(v0, o0, o4);
        check("p100_sat", o0, 511);
        check("p100_shift4", o4, 56);

        // Row-edge suppression: 17 consecutive windows from column 0.
        do_reset();
        load_w(ones);
        idle();
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            foreach (px[j]) px[j] = $urandom_range(0, 60);
            send(px);
        end
        idle(); idle(); idle(); idle();
        check("edge_pulses", pulses, 15);

        // Mid-stream reload: in-flight windows keep the old weights.
        do_reset();
        foreach (wr[i]) wr[i] = int'($urandom_range(0, 8)) - 4;
        load_w(wr);
        for (int i = 0; i < 6; i++) begin
            foreach (px[j]) px[j] = $urandom_range(0, 511);
            send(px);
        end
        for (int i = 0; i < N; i++) begin
            foreach (px[j]) px[j] = $urandom_range(0, 511);
            cycle(1'b0, 1'b1, int'($urandom_range(0, 8)) - 4, 1'b1, px);
        end
        for (int i = 0; i < 20; i++) begin
            foreach (px[j]) px[j] = $urandom_range(0, 511);
            send(px);
        end

        // Randomised traffic with sporadic reloads and resets.
        do_reset();
        foreach (wr[i]) wr[i] = int'($urandom_range(0, 6)) - 3;
        load_w(wr);
        for (int i = 0; i < 3000; i++) begin
            bit rst, wl, wv;
            int wval;
            rst = ($urandom_range(0, 399) == 0);
            wl  = ($urandom_range(0, 11) == 0);
            wv  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) wval = int'($urandom_range(0, 511)) - 256;
            else                           wval = int'($urandom_range(0, 8)) - 4;
            if ($urandom_range(0, 15) == 0) px = p511;
            else foreach (px[j]) px[j] = $urandom_range(0, 511);
            cycle(rst, wl, wval, wv, px);
        end
        for (int i = 0; i < 6; i++) idle();
        check("queue_drained", due_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
